tank_level_model: RTL
=====================

Name: tank_level_model

Overview:
- Cycle-based plant model of the irrigation water tank: the sensor end of the controller interface.
- Consumes the controller's actuator commands: Ve (inlet valve), Vs (drip valve), Bs (sprinkler pump).
- Integrates net water volume per time tick and drives registered level-sensor outputs H, M, L back to the controller.
- Provides hysteresis, stuck-at fault injection and sticky overflow/dry-run flags, so the controller's alarm and error logic can be exercised closed-loop, on board or in simulation.

Parameters:
- PRESCALE, 1000: clock cycles per simulation tick (>=1).
- CAPACITY, 200: maximum tank volume in units (<=255).
- L_THRESH, 40: volume at which the low sensor becomes wet.
- M_THRESH, 100: volume at which the medium sensor becomes wet.
- H_THRESH, 160: volume at which the high sensor becomes wet.
- HYST, 5: a sensor goes dry only when volume < THRESH-HYST.
- FILL_RATE, 3: units added per tick while Ve=1.
- DRIP_RATE, 1: units removed per tick while Vs=1.
- SPRAY_RATE, 2: units removed per tick while Bs=1.
- INIT_LEVEL, 0: volume loaded on reset.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- Ve  in  1  inlet valve command
- Vs  in  1  drip valve command
- Bs  in  1  sprinkler pump command
- freeze  in  1  hold prescaler and volume
- clear_flags  in  1  clear sticky flags
- fault_sel  in  2  00 none, 01 M stuck 0, 10 H stuck 1, 11 L stuck 0
- H  out  1  high sensor (1=wet)
- M  out  1  medium sensor
- L  out  1  low sensor
- level  out  8  current volume
- flow_state  out  2  00 STEADY, 01 FILLING, 10 DRAINING, 11 SATURATED
- tick  out  1  one-cycle pulse per tick
- overflow  out  1  sticky: fill attempted past CAPACITY
- dry  out  1  sticky: outflow demanded at volume 0

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - level=INIT_LEVEL, prescaler=0, flow_state=STEADY.
  - H=M=L=0, tick=0, overflow=0, dry=0.
  - Sensors are first valid one cycle after reset deasserts.
- Prescaler:
  - Counts 0..PRESCALE-1.
  - tick is registered and asserts for one cycle in the cycle after the count wraps.
  - freeze=1 holds the count and suppresses tick.
- Volume update:
  - Occurs on the clock edge at which tick=1.
  - Commands are sampled at that edge.
  - in = Ve?FILL_RATE:0; out = (Vs?DRIP_RATE:0)+(Bs?SPRAY_RATE:0).
  - Compute in a 10-bit signed domain: next = level+in-out, clamped to [0, CAPACITY]. No wrap-around.
- flow_state, updated on the same edge:
  - SATURATED if the clamp engaged.
  - Else FILLING if in>out.
  - Else DRAINING if out>in.
  - Else STEADY. Simultaneous equal in and out gives STEADY with level unchanged.
- Flags:
  - overflow sets when the upper clamp engaged with Ve=1.
  - dry sets when the lower clamp engaged, or out>0 with level=0.
  - Both are sticky. clear_flags clears both on the next edge; a set condition on the same edge wins over clear.
- Sensors:
  - Registered one cycle after the level register (1-cycle latency from level change to sensor change).
  - Each sensor S with threshold T: wet when level>=T; dry when level<T-HYST; otherwise holds its previous value.
  - fault_sel overrides the affected output in the same register stage (1-cycle latency); the internal hysteresis state keeps tracking.
- Sensor consistency: with fault_sel=00 and ordered thresholds, the outputs never show M without L, or H without M.

Test Plan:
- Bench overrides PRESCALE=4; all other parameters at default.
- Fill: reset, Ve=1 -> level 3 per tick; L=1 one cycle after level=42 (tick 14), M after 102 (tick 34), H after 162 (tick 54), flow_state=01.
- Saturation: keep Ve=1 -> tick 67 level clamps at 200 (not 201), flow_state=11, overflow=1; holds at 200 on later ticks.
- Hysteresis: from 162, Ve=0, Vs=1 -> H stays 1 through level 155; H=0 one cycle after level=154; flow_state=10.
- Fault: level 120, fault_sel=01 -> next cycle M=0, L=1, H=0; fault_sel=00 -> M=1 next cycle, with no re-crossing needed.
- Dry run: level 0, Bs=1 -> level stays 0, dry=1; clear_flags with Bs=0 -> dry=0 next cycle; clear_flags with Bs=1 -> dry stays 1.
- Balance and reset: Ve=Vs=Bs=1 -> level unchanged, flow_state=00; freeze=1 -> no tick; reset mid-fill -> all outputs at reset values next cycle, level=INIT_LEVEL.

Source files
------------

// File: rtl/tank_level_model.sv
// Cycle-based irrigation tank plant: integrates valve/pump commands per tick and
// drives hysteretic level sensors, fault overrides and sticky alarm flags.

module tank_level_sensor #(
  parameter int THRESH = 40,
  parameter int HYST   = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] level,
  input  logic       force_en,
  input  logic       force_val,
  output logic       sens_q
);
  logic wet_q, wet_d, sens_d;

  // The hysteresis state keeps tracking even while the output is forced.
  always_comb begin
    wet_d = wet_q;
    if (int'(level) >= THRESH)             wet_d = 1'b1;
    else if (int'(level) < THRESH - HYST)  wet_d = 1'b0;
    sens_d = force_en ? force_val : wet_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wet_q  <= 1'b0;
      sens_q <= 1'b0;
    end else begin
      wet_q  <= wet_d;
      sens_q <= sens_d;
    end
  end
endmodule

module tank_level_model #(
  parameter int PRESCALE   = 1000,
  parameter int CAPACITY   = 200,
  parameter int L_THRESH   = 40,
  parameter int M_THRESH   = 100,
  parameter int H_THRESH   = 160,
  parameter int HYST       = 5,
  parameter int FILL_RATE  = 3,
  parameter int DRIP_RATE  = 1,
  parameter int SPRAY_RATE = 2,
  parameter int INIT_LEVEL = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       Ve,
  input  logic       Vs,
  input  logic       Bs,
  input  logic       freeze,
  input  logic       clear_flags,
  input  logic [1:0] fault_sel,
  output logic       H,
  output logic       M,
  output logic       L,
  output logic [7:0] level,
  output logic [1:0] flow_state,
  output logic       tick,
  output logic       overflow,
  output logic       dry
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int NUM_SENS = 3;
  localparam int THR [NUM_SENS] = '{L_THRESH, M_THRESH, H_THRESH};

  typedef enum logic [1:0] {
    ST_STEADY = 2'b00,
    ST_FILL   = 2'b01,
    ST_DRAIN  = 2'b10,
    ST_SAT    = 2'b11
  } flow_e;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic [7:0]    level_q, level_d;
  flow_e         flow_q, flow_d;
  logic          ovf_q, ovf_d, dry_q, dry_d;

  logic               upd;
  logic signed [9:0]  in_amt, out_amt, sum;
  logic               hi_clamp, lo_clamp;
  logic [NUM_SENS-1:0] force_en, force_val, sens;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (!freeze) begin
      if (cnt_q == CW'(PRESCALE - 1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Signed 10-bit domain so both clamps are detected without wrap-around.
  always_comb begin
    upd      = tick_q && !freeze;
    in_amt   = Ve ? 10'(FILL_RATE) : 10'sd0;
    out_amt  = (Vs ? 10'(DRIP_RATE) : 10'sd0) + (Bs ? 10'(SPRAY_RATE) : 10'sd0);
    sum      = $signed({2'b00, level_q}) + in_amt - out_amt;
    hi_clamp = sum > $signed(10'(CAPACITY));
    lo_clamp = sum < 10'sd0;

    level_d = level_q;
    flow_d  = flow_q;
    ovf_d   = clear_flags ? 1'b0 : ovf_q;
    dry_d   = clear_flags ? 1'b0 : dry_q;
    if (upd) begin
      if (hi_clamp)      level_d = 8'(CAPACITY);
      else if (lo_clamp) level_d = 8'd0;
      else               level_d = sum[7:0];

      if (hi_clamp || lo_clamp)  flow_d = ST_SAT;
      else if (in_amt > out_amt) flow_d = ST_FILL;
      else if (out_amt > in_amt) flow_d = ST_DRAIN;
      else                       flow_d = ST_STEADY;

      if (hi_clamp && Ve) ovf_d = 1'b1;
      if (lo_clamp || (out_amt != 10'sd0 && level_q == 8'd0)) dry_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      level_q <= 8'(INIT_LEVEL);
      flow_q  <= ST_STEADY;
      ovf_q   <= 1'b0;
      dry_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      level_q <= level_d;
      flow_q  <= flow_d;
      ovf_q   <= ovf_d;
      dry_q   <= dry_d;
    end
  end

  // Sensor index 0=L, 1=M, 2=H; fault_sel picks one output to force.
  always_comb begin
    force_en  = '0;
    force_val = '0;
    unique case (fault_sel)
      2'b01:   force_en[1] = 1'b1;
      2'b10:   begin force_en[2] = 1'b1; force_val[2] = 1'b1; end
      2'b11:   force_en[0] = 1'b1;
      default: ;
    endcase
  end

  genvar g;
  generate
    for (g = 0; g < NUM_SENS; g++) begin : g_sens
      tank_level_sensor #(.THRESH(THR[g]), .HYST(HYST)) u_sens (
        .clock     (clock),
        .reset     (reset),
        .level     (level_q),
        .force_en  (force_en[g]),
        .force_val (force_val[g]),
        .sens_q    (sens[g])
      );
    end
  endgenerate

  assign L          = sens[0];
  assign M          = sens[1];
  assign H          = sens[2];
  assign level      = level_q;
  assign flow_state = flow_q;
  assign tick       = tick_q;
  assign overflow   = ovf_q;
  assign dry        = dry_q;
endmodule
